mem2_dmem_ctrl: RTL

- Second memory stage; sits directly downstream of the MEM stage-1 request outputs (size, read/write strobes, address, write data).
- Converts each request into a byte-lane access on a single-port word-wide data SRAM, waits for the SRAM ready handshake, then returns the aligned, sign- or zero-extended load word.
- Stalls the pipeline while an access is in flight and flags misaligned or timed-out accesses.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_lane_align.sv | 52 +++++
 rtl/mem2_dmem_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the second memory stage: access sizes, controller
// states, error causes and the alignment rule used at request time.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10,
        ERR    = 2'b11
    } state_t;

    localparam logic CAUSE_MISALIGN = 1'b0;
    localparam logic CAUSE_BUSERR   = 1'b1;

    // A request is rejected when its size is illegal or its address is not
    // a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && offset[0]) ||
               ((size == SZ_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the core's right-justified data and the
// word-wide SRAM: byte enables, store replication and load extraction.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] raw_word,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick lanes from size and offset; the illegal size selects nothing.
    always_comb begin
        be         = 4'b0000;
        lane_wdata = 32'h0;
        load_word  = 32'h0;
        sel_byte   = raw_word[{offset, 3'b000} +: 8];
        sel_half   = offset[1] ? raw_word[31:16] : raw_word[15:0];
        case (size)
            SZ_BYTE: begin
                be         = 4'b0001 << offset;
                lane_wdata = {4{store_data[7:0]}};
                load_word  = is_unsigned ? {24'h0, sel_byte}
                                         : {{24{sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                be         = offset[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{store_data[15:0]}};
                load_word  = is_unsigned ? {16'h0, sel_half}
                                         : {{16{sel_half[15]}}, sel_half};
            end
            SZ_WORD: begin
                be         = 4'b1111;
                lane_wdata = store_data;
                load_word  = raw_word;
            end
            default: begin
                be         = 4'b0000;
                lane_wdata = 32'h0;
                load_word  = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem2_dmem_ctrl.sv
// Second memory stage: turns a stage-1 load/store request into one SRAM
// access, stalls until the SRAM answers or times out, and returns the
// extended load word or an error pulse.
module mem2_dmem_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MEM_inVALID,
    input  logic [1:0]  MEM_inSIZE,
    input  logic        MEM_inMEMWRITE,
    input  logic        MEM_inMEMREAD,
    input  logic        MEM_inUNSIGNED,
    input  logic [31:0] MEM_inADDRESS,
    input  logic [31:0] MEM_inWRITEDATA,
    input  logic [31:0] DM_inRDATA,
    input  logic        DM_inREADY,
    output logic        MEM_outSTALL,
    output logic [31:0] MEM_outLOADDATA,
    output logic        MEM_outLOADVALID,
    output logic        MEM_outMISALIGN,
    output logic        MEM_outBUSERR,
    output logic        DM_outEN,
    output logic        DM_outWE,
    output logic [3:0]  DM_outBE,
    output logic [29:0] DM_outADDR,
    output logic [31:0] DM_outWDATA
);

    state_t        state;
    logic [TW-1:0] cnt;
    logic [1:0]    size_q;
    logic          unsigned_q;
    logic [31:0]   addr_q;
    logic          write_q;
    logic [31:0]   wdata_q;
    logic          cause_q;
    logic [31:0]   load_data;

    logic          request;
    logic          misaligned;
    logic          in_access;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata;
    logic [31:0]   lane_load;

    assign request    = MEM_inVALID & (MEM_inMEMREAD | MEM_inMEMWRITE);
    assign misaligned = is_misaligned(MEM_inSIZE, MEM_inADDRESS[1:0]);
    assign in_access  = (state == ACCESS);

    mem_lane_align u_align (
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_unsigned (unsigned_q),
        .store_data  (wdata_q),
        .raw_word    (DM_inRDATA),
        .be          (lane_be),
        .lane_wdata  (lane_wdata),
        .load_word   (lane_load)
    );

    // Request latching, SRAM wait with timeout, and one-cycle result/error.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            cnt        <= '0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0;
            write_q    <= 1'b0;
            wdata_q    <= 32'h0;
            cause_q    <= CAUSE_MISALIGN;
            load_data  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        if (misaligned) begin
                            cause_q <= CAUSE_MISALIGN;
                            state   <= ERR;
                        end else begin
                            size_q     <= MEM_inSIZE;
                            unsigned_q <= MEM_inUNSIGNED;
                            addr_q     <= MEM_inADDRESS;
                            write_q    <= MEM_inMEMWRITE;
                            wdata_q    <= MEM_inMEMWRITE ? MEM_inWRITEDATA : 32'h0;
                            cnt        <= '0;
                            state      <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (DM_inREADY) begin
                        if (!write_q) begin
                            load_data <= lane_load;
                        end
                        state <= RESP;
                    end else if (cnt == TW'(TIMEOUT - 1)) begin
                        cause_q <= CAUSE_BUSERR;
                        state   <= ERR;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // SRAM side is only driven while an access is in flight.
    always_comb begin
        DM_outEN    = in_access;
        DM_outWE    = in_access & write_q;
        DM_outBE    = in_access ? lane_be : 4'b0000;
        DM_outADDR  = in_access ? addr_q[31:2] : 30'h0;
        DM_outWDATA = in_access ? lane_wdata : 32'h0;
    end

    // Pipeline side: stall while accepting or waiting, pulse results after.
    always_comb begin
        MEM_outSTALL     = RST_N & (((state == IDLE) & request) | in_access);
        MEM_outLOADDATA  = load_data;
        MEM_outLOADVALID = (state == RESP) & ~write_q;
        MEM_outMISALIGN  = (state == ERR) & (cause_q == CAUSE_MISALIGN);
        MEM_outBUSERR    = (state == ERR) & (cause_q == CAUSE_BUSERR);
    end

endmodule
